trex_ctrl: RTL
==============

# trex_ctrl

Parametrised T-rex character controller for the runner game: frame-strobed state machine and jump physics that produce the character's position, bounding box and sprite frame for the renderer and collision logic. It adds the following to the fixed per-clock controller:
- a one-cycle frame tick, with jump requests captured between ticks;
- working ducking;
- speed-drop while airborne;
- a max-height cutoff and ground clamping;
- crash/restart recovery.

## Interface
- `POS_W`, 10: width of `x_pos`/`y_pos`
- `VEL_W`, 8: signed velocity width
- `SPEED_W`, 4: width of `speed`
- `START_X`, 50: fixed x position
- `GROUND_Y`, 93: y on the ground (150−47−10)
- `HEIGHT` / `HEIGHT_DUCK`, 47 / 25: box height when standing / ducking
- `WIDTH` / `WIDTH_DUCK`, 44 / 59: box width when standing / ducking
- `INIT_JUMP_VEL`, −10: base launch velocity (negative is up)
- `SPEED_SHIFT`, 3: launch velocity is `INIT_JUMP_VEL − (speed >> SPEED_SHIFT)`
- `GRAV_NUM` / `GRAV_DEN`, 6 / 10: fractional gravity, +1 velocity per `GRAV_DEN/GRAV_NUM` ticks
- `MIN_JUMP_H` / `MAX_JUMP_H`, 30 / 60: heights above `GROUND_Y`
- `DROP_VEL`, −5: velocity cap on jump release or at max height
- `FAST_DROP_VEL`, 4: downward velocity forced by duck while airborne

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `tick` in 1: one-cycle frame strobe (60 Hz)
- `timer` in 6: frame counter, 0..59
- `speed` in `SPEED_W`: game speed
- `jump` in 1: jump button level
- `duck` in 1: duck button level
- `crash` in 1: collision flag
- `restart` in 1: restart request
- `x_pos` out `POS_W`: character x
- `y_pos` out `POS_W`: character y
- `box_w` out 7: bounding-box width
- `box_h` out 6: bounding-box height
- `frame` out `frame_t`: sprite frame
- `state` out `state_t`: controller state

## Operation
**States:** WAITING, RUNNING, JUMPING, DUCKING, CRASHED. Transitions are evaluated only in a cycle with `tick`=1.

**Jump request latch:**
- `jump_req` is set by any cycle with `jump`=1.
- It is cleared in every tick cycle, after use.
- The tick cycle itself sees `jump_req | jump`.

**Transitions, by priority:**
- `crash` in RUNNING, JUMPING or DUCKING → CRASHED. Velocity, y and frame freeze.
- CRASHED: `restart` → RUNNING with `y_pos`=`GROUND_Y`, velocity 0 and gravity accumulator 0. Otherwise stay CRASHED. `restart` is ignored in all other states.
- WAITING or RUNNING:
  - jump request → JUMPING; this wins over `duck`.
  - RUNNING with `duck` → DUCKING.
- DUCKING: jump request → JUMPING; `duck`=0 → RUNNING.
- JUMPING: landing → DUCKING if `duck`, else RUNNING.

**Jump entry tick:**
- `vel` ← `INIT_JUMP_VEL − (speed >> SPEED_SHIFT)`.
- `acc` ← 0, `reached_min` ← 0.
- `y_pos` is unchanged.

**Each later JUMPING tick:**
- `y_next` = `y_pos + vel`, computed signed at `POS_W+1` bits.
- Gravity: `acc` += `GRAV_NUM`. If `acc` ≥ `GRAV_DEN`: `acc` −= `GRAV_DEN` and `vel` += 1.
- If `y_pos` < `GROUND_Y − MIN_JUMP_H`, set `reached_min`.
- `vel` is overridden to `DROP_VEL` (only when `vel` < `DROP_VEL`) in either case:
  - `reached_min` and `jump`=0;
  - `y_pos` < `GROUND_Y − MAX_JUMP_H`.
- `duck`=1 forces `vel` ← `FAST_DROP_VEL`, overriding the above.
- Landing: if `y_next` ≥ `GROUND_Y`, then `y_pos` ← `GROUND_Y`, `vel` ← 0, `acc` ← 0. There is no overshoot.
- If `y_next` < 0, clamp `y_pos` to 0.

**Box size:** `box_w`/`box_h` = `WIDTH_DUCK`/`HEIGHT_DUCK` in DUCKING, otherwise `WIDTH`/`HEIGHT`. `x_pos` is constant `START_X`.

**Frame, chosen from the next state on each tick:**
- WAITING: `timer` ≥ 30 → WAITING0, else WAITING1.
- RUNNING: `timer` mod 10 < 5 → RUNNING0, else RUNNING1.
- DUCKING: `timer` mod 20 < 10 → DUCKING0, else DUCKING1.
- JUMPING → JUMPING0.
- CRASHED → CRASHED0.

## Timing
- **Reset values:** `state`=WAITING, `frame`=WAITING0, `x_pos`=`START_X`, `y_pos`=`GROUND_Y`, `box_w`=`WIDTH`, `box_h`=`HEIGHT`. Velocity, `acc`, `reached_min` and `jump_req` are all 0.
- All outputs are registered and change only in the cycle after a tick cycle. They hold between ticks.
- `rst` mid-jump returns everything to the reset values on the next edge, regardless of `tick`.
- `tick` on consecutive cycles is legal; each one is a full physics step.
- `crash` and `restart` are sampled only on tick cycles and are not latched.

## Structure
- Package `trex_ctrl_pkg`: `frame_t` (WAITING0, WAITING1, RUNNING0, RUNNING1, JUMPING0, DUCKING0, DUCKING1, CRASHED0), `state_t`, and the default physics and geometry constants.
- One sub-module, `trex_frame_sel`: combinational frame selection from next state and `timer`.

## Test plan
- **Reset, then first jump:** reset, hold `jump` 1 cycle between ticks, `speed`=8 → after the next tick, state=JUMPING, `y_pos`=93, `vel`=−11.
- **Jump arc:** continue the jump → `y_pos` 82, then 71 (`vel` → −10 at the second step). Landing clamps to exactly 93 and gives RUNNING. No `y_pos` > 93 is ever seen.
- **Jump release:** release `jump` after `y_pos` < 63 → `vel` becomes −5 next tick. Hold `jump` instead → the max-height cutoff applies once `y_pos` < 33.
- **Duck:** in RUNNING with `duck`=1, `timer`=12 → DUCKING, DUCKING1, `box_h`=25, `box_w`=59. With `timer`=5 → DUCKING0.
- **Speed-drop and land into duck:** `duck` while airborne → `vel`=4. Keep holding → lands in DUCKING.
- **Crash and restart:** `crash` mid-jump → CRASHED/CRASHED0 with `y_pos` frozen. `restart` in RUNNING has no effect. `restart` in CRASHED → RUNNING, `y_pos`=93.

Source files
------------

// File: rtl/trex_ctrl_pkg.sv
// Shared types and default physics/geometry constants for the T-rex controller.
package trex_ctrl_pkg;

  typedef enum logic [2:0] {
    WAITING, RUNNING, JUMPING, DUCKING, CRASHED
  } state_t;

  typedef enum logic [2:0] {
    WAITING0, WAITING1, RUNNING0, RUNNING1, JUMPING0, DUCKING0, DUCKING1, CRASHED0
  } frame_t;

  localparam int TREX_POS_W         = 10;
  localparam int TREX_VEL_W         = 8;
  localparam int TREX_SPEED_W       = 4;
  localparam int TREX_START_X       = 50;
  localparam int TREX_GROUND_Y      = 93;   // 150 - 47 - 10
  localparam int TREX_HEIGHT        = 47;
  localparam int TREX_HEIGHT_DUCK   = 25;
  localparam int TREX_WIDTH         = 44;
  localparam int TREX_WIDTH_DUCK    = 59;
  localparam int TREX_INIT_JUMP_VEL = -10;
  localparam int TREX_SPEED_SHIFT   = 3;
  localparam int TREX_GRAV_NUM      = 6;
  localparam int TREX_GRAV_DEN      = 10;
  localparam int TREX_MIN_JUMP_H    = 30;
  localparam int TREX_MAX_JUMP_H    = 60;
  localparam int TREX_DROP_VEL      = -5;
  localparam int TREX_FAST_DROP_VEL = 4;

  // Gravity accumulator width; holds up to GRAV_DEN + GRAV_NUM.
  localparam int TREX_ACC_W         = 8;

endpackage

// File: rtl/trex_frame_sel.sv
// Combinational sprite-frame selection from the upcoming state and frame timer.
module trex_frame_sel
  import trex_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_timer,
  output frame_t      o_frame
);

  logic [5:0] w_mod10;
  logic [5:0] w_mod20;

  assign w_mod10 = i_timer % 6'd10;
  assign w_mod20 = i_timer % 6'd20;

  // Animation phase: waiting blinks at half-second, run at 6 Hz, duck at 3 Hz.
  always_comb begin
    o_frame = WAITING0;
    case (i_state)
      WAITING: o_frame = (i_timer >= 6'd30) ? WAITING0 : WAITING1;
      RUNNING: o_frame = (w_mod10 < 6'd5)   ? RUNNING0 : RUNNING1;
      DUCKING: o_frame = (w_mod20 < 6'd10)  ? DUCKING0 : DUCKING1;
      JUMPING: o_frame = JUMPING0;
      CRASHED: o_frame = CRASHED0;
      default: o_frame = WAITING0;
    endcase
  end

endmodule

// File: rtl/trex_ctrl.sv
// T-rex character controller: frame-strobed state machine plus jump physics.
// All state and outputs advance only on tick cycles; jump presses between
// ticks are remembered so short taps are not lost.
module trex_ctrl
  import trex_ctrl_pkg::*;
#(
  parameter int POS_W         = TREX_POS_W,
  parameter int VEL_W         = TREX_VEL_W,
  parameter int SPEED_W       = TREX_SPEED_W,
  parameter int START_X       = TREX_START_X,
  parameter int GROUND_Y      = TREX_GROUND_Y,
  parameter int HEIGHT        = TREX_HEIGHT,
  parameter int HEIGHT_DUCK   = TREX_HEIGHT_DUCK,
  parameter int WIDTH         = TREX_WIDTH,
  parameter int WIDTH_DUCK    = TREX_WIDTH_DUCK,
  parameter int INIT_JUMP_VEL = TREX_INIT_JUMP_VEL,
  parameter int SPEED_SHIFT   = TREX_SPEED_SHIFT,
  parameter int GRAV_NUM      = TREX_GRAV_NUM,
  parameter int GRAV_DEN      = TREX_GRAV_DEN,
  parameter int MIN_JUMP_H    = TREX_MIN_JUMP_H,
  parameter int MAX_JUMP_H    = TREX_MAX_JUMP_H,
  parameter int DROP_VEL      = TREX_DROP_VEL,
  parameter int FAST_DROP_VEL = TREX_FAST_DROP_VEL
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [5:0]         timer,
  input  logic [SPEED_W-1:0] speed,
  input  logic               jump,
  input  logic               duck,
  input  logic               crash,
  input  logic               restart,
  output logic [POS_W-1:0]   x_pos,
  output logic [POS_W-1:0]   y_pos,
  output logic [6:0]         box_w,
  output logic [5:0]         box_h,
  output frame_t             frame,
  output state_t             state
);

  localparam int ACC_W = TREX_ACC_W;

  localparam logic signed [VEL_W-1:0] C_INIT_VEL = VEL_W'(INIT_JUMP_VEL);
  localparam logic signed [VEL_W-1:0] C_DROP_VEL = VEL_W'(DROP_VEL);
  localparam logic signed [VEL_W-1:0] C_FAST_VEL = VEL_W'(FAST_DROP_VEL);
  localparam logic signed [POS_W:0]   C_GROUND_S = (POS_W+1)'(GROUND_Y);
  localparam logic [POS_W-1:0]        C_GROUND   = POS_W'(GROUND_Y);
  localparam logic [POS_W-1:0]        C_MIN_Y    = POS_W'(GROUND_Y - MIN_JUMP_H);
  localparam logic [POS_W-1:0]        C_MAX_Y    = POS_W'(GROUND_Y - MAX_JUMP_H);

  state_t                   r_state, w_state_nx;
  frame_t                   r_frame, w_frame_nx;
  logic [POS_W-1:0]         r_y, w_y_nx;
  logic signed [VEL_W-1:0]  r_vel, w_vel_nx;
  logic [ACC_W-1:0]         r_acc, w_acc_nx;
  logic                     r_min, w_min_nx;
  logic                     r_jreq;
  logic [6:0]               r_box_w;
  logic [5:0]               r_box_h;

  logic                     w_jreq;
  logic [SPEED_W-1:0]       w_spd_sh;
  logic signed [VEL_W-1:0]  w_vel_launch;
  logic signed [POS_W:0]    w_y_sum;
  logic [ACC_W-1:0]         w_acc_sum, w_acc_g;
  logic                     w_carry;
  logic signed [VEL_W-1:0]  w_vel_g, w_vel_cut, w_vel_air;
  logic                     w_min_g, w_cut, w_land;

  // The tick cycle honours both a latched press and a press on that very cycle.
  assign w_jreq       = r_jreq | jump;
  assign w_spd_sh     = speed >> SPEED_SHIFT;
  assign w_vel_launch = C_INIT_VEL - $signed(VEL_W'(w_spd_sh));

  // Position step uses the velocity from before this tick's gravity update.
  assign w_y_sum   = $signed({1'b0, r_y}) +
                     $signed({{(POS_W+1-VEL_W){r_vel[VEL_W-1]}}, r_vel});
  assign w_land    = (w_y_sum >= C_GROUND_S);

  // Fractional gravity: one velocity unit each time the accumulator wraps.
  assign w_acc_sum = r_acc + ACC_W'(GRAV_NUM);
  assign w_carry   = (w_acc_sum >= ACC_W'(GRAV_DEN));
  assign w_acc_g   = w_carry ? (w_acc_sum - ACC_W'(GRAV_DEN)) : w_acc_sum;
  assign w_vel_g   = r_vel + $signed({{(VEL_W-1){1'b0}}, w_carry});

  // Short-hop release and ceiling both cap the upward speed; ducking dives.
  assign w_min_g   = r_min | (r_y < C_MIN_Y);
  assign w_cut     = (w_min_g & ~jump) | (r_y < C_MAX_Y);
  assign w_vel_cut = (w_cut && (w_vel_g < C_DROP_VEL)) ? C_DROP_VEL : w_vel_g;
  assign w_vel_air = duck ? C_FAST_VEL : w_vel_cut;

  // Next-state and physics update for the coming tick.
  always_comb begin
    w_state_nx = r_state;
    w_y_nx     = r_y;
    w_vel_nx   = r_vel;
    w_acc_nx   = r_acc;
    w_min_nx   = r_min;
    if (crash && (r_state == RUNNING || r_state == JUMPING || r_state == DUCKING)) begin
      w_state_nx = CRASHED;
    end else begin
      case (r_state)
        CRASHED: begin
          if (restart) begin
            w_state_nx = RUNNING;
            w_y_nx     = C_GROUND;
            w_vel_nx   = '0;
            w_acc_nx   = '0;
          end
        end
        WAITING, RUNNING, DUCKING: begin
          if (w_jreq) begin
            w_state_nx = JUMPING;
            w_vel_nx   = w_vel_launch;
            w_acc_nx   = '0;
            w_min_nx   = 1'b0;
          end else if (r_state == RUNNING && duck) begin
            w_state_nx = DUCKING;
          end else if (r_state == DUCKING && !duck) begin
            w_state_nx = RUNNING;
          end
        end
        JUMPING: begin
          w_min_nx = w_min_g;
          if (w_land) begin
            w_state_nx = duck ? DUCKING : RUNNING;
            w_y_nx     = C_GROUND;
            w_vel_nx   = '0;
            w_acc_nx   = '0;
          end else begin
            w_y_nx   = w_y_sum[POS_W] ? '0 : w_y_sum[POS_W-1:0];
            w_vel_nx = w_vel_air;
            w_acc_nx = w_acc_g;
          end
        end
        default: w_state_nx = WAITING;
      endcase
    end
  end

  trex_frame_sel u_frame_sel (
    .i_state (w_state_nx),
    .i_timer (timer),
    .o_frame (w_frame_nx)
  );

  // State, physics and output registers; only tick cycles commit an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAITING;
      r_frame <= WAITING0;
      r_y     <= C_GROUND;
      r_vel   <= '0;
      r_acc   <= '0;
      r_min   <= 1'b0;
      r_jreq  <= 1'b0;
      r_box_w <= 7'(WIDTH);
      r_box_h <= 6'(HEIGHT);
    end else begin
      r_jreq <= tick ? 1'b0 : (r_jreq | jump);
      if (tick) begin
        r_state <= w_state_nx;
        r_frame <= w_frame_nx;
        r_y     <= w_y_nx;
        r_vel   <= w_vel_nx;
        r_acc   <= w_acc_nx;
        r_min   <= w_min_nx;
        r_box_w <= (w_state_nx == DUCKING) ? 7'(WIDTH_DUCK)  : 7'(WIDTH);
        r_box_h <= (w_state_nx == DUCKING) ? 6'(HEIGHT_DUCK) : 6'(HEIGHT);
      end
    end
  end

  assign x_pos = POS_W'(START_X);
  assign y_pos = r_y;
  assign box_w = r_box_w;
  assign box_h = r_box_h;
  assign frame = r_frame;
  assign state = r_state;

endmodule
